// File: rtl/control_fsm_pkg.sv
// control_fsm_pkg: shared types and constants for the RV32I multi-cycle control FSM.
// Latency: n/a (types, constants and one combinational helper only).
// Backpressure: n/a.
// Contents: alu_op_t class, control_state_t, opcode constants, mux select encodings,
// and is_supported_opcode() used to flag illegal instructions in DECODE.
package control_fsm_pkg;

  // Operation class handed to the ALU decoder.
  typedef enum logic [1:0] {
    ALU_OP__MEMORY_ACCESS      = 2'b00,
    ALU_OP__BRANCH             = 2'b01,
    ALU_OP__REGISTER_OPERATION = 2'b10,
    ALU_OP__UNSET              = 2'b11
  } alu_op_t;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEM_ADR,
    ST_MEM_READ,
    ST_MEM_WB,
    ST_MEM_WRITE,
    ST_EXEC_R,
    ST_EXEC_I,
    ST_LUI,
    ST_ALU_WB,
    ST_JAL,
    ST_JALR,
    ST_JALR_LINK,
    ST_BRANCH
  } control_state_t;

  localparam logic [6:0] OPCODE__LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE__STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE__OP     = 7'b0110011;
  localparam logic [6:0] OPCODE__OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE__BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE__JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE__JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE__LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE__AUIPC  = 7'b0010111;

  // ALU A operand select
  localparam logic [1:0] SRC_A__PC     = 2'b00;
  localparam logic [1:0] SRC_A__OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A__RS1    = 2'b10;
  localparam logic [1:0] SRC_A__ZERO   = 2'b11;

  // ALU B operand select
  localparam logic [1:0] SRC_B__RS2  = 2'b00;
  localparam logic [1:0] SRC_B__IMM  = 2'b01;
  localparam logic [1:0] SRC_B__FOUR = 2'b10;

  // Result mux select
  localparam logic [1:0] RESULT__ALU_OUT    = 2'b00;
  localparam logic [1:0] RESULT__MEM_DATA   = 2'b01;
  localparam logic [1:0] RESULT__ALU_RESULT = 2'b10;

  function automatic logic is_supported_opcode(input logic [6:0] op);
    case (op)
      OPCODE__LOAD, OPCODE__STORE, OPCODE__OP, OPCODE__OP_IMM, OPCODE__BRANCH,
      OPCODE__JAL, OPCODE__JALR, OPCODE__LUI, OPCODE__AUIPC: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_fsm_branch_cond.sv
// control_fsm_branch_cond: resolves branch taken from funct3 and the ALU zero flag.
// Latency: combinational.
// Backpressure: none.
// Ports: funct3 (instr[14:12]), zero (ALU result == 0) -> taken.
module control_fsm_branch_cond (
  input  logic [2:0] funct3,
  input  logic       zero,
  output logic       taken
);

  // BEQ subtracts, so equality means a zero result. Every other branch either
  // subtracts (BNE) or uses a compare op that yields 1 when the condition holds,
  // so a non-zero result means taken.
  assign taken = (funct3 == 3'b000) ? zero : ~zero;

endmodule

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle RV32I main control (fetch/decode/execute/memory/writeback).
// Latency: 3-5 cycles per instruction plus one cycle per memory wait cycle.
// Backpressure: FETCH, MEM_READ, MEM_WRITE hold on mem_ready=0 only when
// CONTROL_FSM_MEM_WAIT_EN is defined; otherwise mem_ready is ignored (port kept).
// Ports: clk, reset (sync, active-high), opcode, funct3, zero, mem_ready in;
// alu_op, alu_src_a, alu_src_b, result_src, adr_src, ir_write, pc_update,
// reg_write, mem_write, illegal_instr out (combinational from state).
module control_fsm
  import control_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output alu_op_t    alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_update,
  output logic       reg_write,
  output logic       mem_write,
  output logic       illegal_instr
);

  control_state_t state_q, state_d;
  logic           mem_rdy;
  logic           taken;

`ifdef CONTROL_FSM_MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  // Memory is assumed single-cycle; the port stays for interface stability.
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_rdy          = 1'b1;
`endif

  control_fsm_branch_cond u_branch_cond (
    .funct3 (funct3),
    .zero   (zero),
    .taken  (taken)
  );

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      ST_FETCH:     if (mem_rdy) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OPCODE__LOAD, OPCODE__STORE: state_d = ST_MEM_ADR;
          OPCODE__OP:                  state_d = ST_EXEC_R;
          OPCODE__OP_IMM:              state_d = ST_EXEC_I;
          OPCODE__BRANCH:              state_d = ST_BRANCH;
          OPCODE__JAL:                 state_d = ST_JAL;
          OPCODE__JALR:                state_d = ST_JALR;
          OPCODE__LUI:                 state_d = ST_LUI;
          // AUIPC: DECODE already left old_pc+imm in alu_out.
          OPCODE__AUIPC:               state_d = ST_ALU_WB;
          default:                     state_d = ST_FETCH;
        endcase
      end
      // opcode[5] separates STORE (0100011) from LOAD (0000011).
      ST_MEM_ADR:   state_d = opcode[5] ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  if (mem_rdy) state_d = ST_MEM_WB;
      ST_MEM_WB:    state_d = ST_FETCH;
      ST_MEM_WRITE: if (mem_rdy) state_d = ST_FETCH;
      ST_EXEC_R:    state_d = ST_ALU_WB;
      ST_EXEC_I:    state_d = ST_ALU_WB;
      ST_LUI:       state_d = ST_ALU_WB;
      ST_ALU_WB:    state_d = ST_FETCH;
      ST_JAL:       state_d = ST_ALU_WB;
      ST_JALR:      state_d = ST_JALR_LINK;
      ST_JALR_LINK: state_d = ST_FETCH;
      ST_BRANCH:    state_d = ST_FETCH;
      default:      state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin : outputs
    alu_op        = ALU_OP__MEMORY_ACCESS;
    alu_src_a     = SRC_A__PC;
    alu_src_b     = SRC_B__RS2;
    result_src    = RESULT__ALU_OUT;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_update     = 1'b0;
    reg_write     = 1'b0;
    mem_write     = 1'b0;
    illegal_instr = 1'b0;
    case (state_q)
      ST_FETCH: begin
        alu_src_b  = SRC_B__FOUR;
        result_src = RESULT__ALU_RESULT;
        // Latch IR and advance PC only on the cycle the fetch completes.
        ir_write   = mem_rdy;
        pc_update  = mem_rdy;
      end
      ST_DECODE: begin
        alu_src_a     = SRC_A__OLD_PC;
        alu_src_b     = SRC_B__IMM;
        illegal_instr = ~is_supported_opcode(opcode);
      end
      ST_MEM_ADR: begin
        alu_src_a = SRC_A__RS1;
        alu_src_b = SRC_B__IMM;
      end
      ST_MEM_READ:  adr_src = 1'b1;
      ST_MEM_WB: begin
        result_src = RESULT__MEM_DATA;
        reg_write  = 1'b1;
      end
      ST_MEM_WRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      ST_EXEC_R: begin
        alu_src_a = SRC_A__RS1;
        alu_src_b = SRC_B__RS2;
        alu_op    = ALU_OP__REGISTER_OPERATION;
      end
      ST_EXEC_I: begin
        alu_src_a = SRC_A__RS1;
        alu_src_b = SRC_B__IMM;
        alu_op    = ALU_OP__UNSET;
      end
      ST_LUI: begin
        alu_src_a = SRC_A__ZERO;
        alu_src_b = SRC_B__IMM;
      end
      ST_ALU_WB: begin
        result_src = RESULT__ALU_OUT;
        reg_write  = 1'b1;
      end
      ST_JAL: begin
        // Target old_pc+imm is in alu_out from DECODE; compute old_pc+4 for the link.
        alu_src_a  = SRC_A__OLD_PC;
        alu_src_b  = SRC_B__FOUR;
        result_src = RESULT__ALU_OUT;
        pc_update  = 1'b1;
      end
      ST_JALR: begin
        alu_src_a  = SRC_A__RS1;
        alu_src_b  = SRC_B__IMM;
        result_src = RESULT__ALU_RESULT;
        pc_update  = 1'b1;
      end
      ST_JALR_LINK: begin
        alu_src_a  = SRC_A__OLD_PC;
        alu_src_b  = SRC_B__FOUR;
        result_src = RESULT__ALU_RESULT;
        reg_write  = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a  = SRC_A__RS1;
        alu_src_b  = SRC_B__RS2;
        alu_op     = ALU_OP__BRANCH;
        result_src = RESULT__ALU_OUT;
        pc_update  = taken;
      end
      default: ;
    endcase
    // Reset aborts whatever is in flight: no strobe may escape this cycle.
    if (reset) begin
      alu_op        = ALU_OP__MEMORY_ACCESS;
      alu_src_a     = SRC_A__PC;
      alu_src_b     = SRC_B__RS2;
      result_src    = RESULT__ALU_OUT;
      adr_src       = 1'b0;
      ir_write      = 1'b0;
      pc_update     = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      illegal_instr = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed plus randomized instruction streams for control_fsm.
// Each instruction is expanded into its list of steps; every cycle the outputs
// are compared against the step's expected strobes/selects, and per instruction
// the cycle count and reg_write pulse count are checked against CPI tables.
module tb_control_fsm;
  import control_fsm_pkg::*;

`ifdef CONTROL_FSM_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  localparam int K_FETCH = 0,  K_DECODE = 1, K_MEMADR = 2, K_MEMRD = 3, K_MEMWB = 4;
  localparam int K_MEMWR = 5,  K_EXR    = 6, K_EXI    = 7, K_LUI   = 8, K_ALUWB = 9;
  localparam int K_JAL   = 10, K_JALR   = 11, K_JLINK = 12, K_BR    = 13, K_ILL  = 14;

  string kind_name [0:14] = '{"fetch", "decode", "mem_adr", "mem_read", "mem_wb",
                              "mem_write", "exec_r", "exec_i", "lui", "alu_wb",
                              "jal", "jalr", "jalr_link", "branch", "illegal"};

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  alu_op_t    alu_op;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic       adr_src, ir_write, pc_update, reg_write, mem_write, illegal_instr;

  int n_checks = 0;
  int n_fail   = 0;

  control_fsm dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .funct3        (funct3),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .alu_op        (alu_op),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .result_src    (result_src),
    .adr_src       (adr_src),
    .ir_write      (ir_write),
    .pc_update     (pc_update),
    .reg_write     (reg_write),
    .mem_write     (mem_write),
    .illegal_instr (illegal_instr)
  );

  always #5 clk = ~clk;

  // Branch semantics: BEQ taken on equal (SUB gives 0); BNE on not-equal;
  // the compare ops return 1 when their condition holds.
  function automatic bit branch_taken(input logic [2:0] f3, input bit z);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      default: return !z;
    endcase
  endfunction

  // Expected {alu_op, a, b, result_src, adr_src, ir_write, pc_update, reg_write, mem_write, illegal}
  function automatic logic [13:0] expect_out(input int kind, input bit rst, input bit mr, input bit tk);
    logic [1:0] op, a, b, rs;
    bit adr, irw, pcu, rw, mw, ill;
    op = 2'b00; a = 2'b00; b = 2'b00; rs = 2'b00;
    adr = 0; irw = 0; pcu = 0; rw = 0; mw = 0; ill = 0;
    if (!rst) begin
      case (kind)
        K_FETCH:  begin b = 2'b10; rs = 2'b10; irw = mr; pcu = mr; end
        K_DECODE: begin a = 2'b01; b = 2'b01; end
        K_ILL:    begin a = 2'b01; b = 2'b01; ill = 1; end
        K_MEMADR: begin a = 2'b10; b = 2'b01; end
        K_MEMRD:  adr = 1;
        K_MEMWB:  begin rs = 2'b01; rw = 1; end
        K_MEMWR:  begin adr = 1; mw = 1; end
        K_EXR:    begin a = 2'b10; b = 2'b00; op = ALU_OP__REGISTER_OPERATION; end
        K_EXI:    begin a = 2'b10; b = 2'b01; op = ALU_OP__UNSET; end
        K_LUI:    begin a = 2'b11; b = 2'b01; end
        K_ALUWB:  begin rs = 2'b00; rw = 1; end
        K_JAL:    begin a = 2'b01; b = 2'b10; rs = 2'b00; pcu = 1; end
        K_JALR:   begin a = 2'b10; b = 2'b01; rs = 2'b10; pcu = 1; end
        K_JLINK:  begin a = 2'b01; b = 2'b10; rs = 2'b10; rw = 1; end
        K_BR:     begin a = 2'b10; b = 2'b00; op = ALU_OP__BRANCH; pcu = tk; end
        default:  ;
      endcase
    end
    return {op, a, b, rs, adr, irw, pcu, rw, mw, ill};
  endfunction

  // One clock cycle: drive inputs (mr_f/z_f: 0/1 forced, 2 random), check outputs
  // mid-cycle, then advance. adv reports whether the step completes this cycle.
  task automatic step(input int kind, input int mr_f, input int z_f, input bit rst,
                      output bit adv, output bit rw_obs);
    bit mr_drv, z_drv, mr_eff;
    logic [13:0] exp_v, obs_v;
    mr_drv = (mr_f == 2) ? ($urandom_range(0, 2) != 0) : mr_f[0];
    z_drv  = (z_f == 2) ? 1'($urandom_range(0, 1)) : z_f[0];
    mr_eff = WAIT_EN ? mr_drv : 1'b1;
    reset = rst; mem_ready = mr_drv; zero = z_drv;
    exp_v = expect_out(kind, rst, mr_eff, branch_taken(funct3, z_drv));
    @(negedge clk);
    obs_v = {alu_op, alu_src_a, alu_src_b, result_src, adr_src, ir_write, pc_update,
             reg_write, mem_write, illegal_instr};
    n_checks++;
    assert (obs_v === exp_v) else begin
      n_fail++;
      $error("FAIL %s%s: observed %h expected %h", rst ? "reset/" : "", kind_name[kind], obs_v, exp_v);
    end
    rw_obs = reg_write;
    adv = (kind == K_FETCH || kind == K_MEMRD || kind == K_MEMWR) ? mr_eff : 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Run one full instruction. rd_waits < 0: random memory waits everywhere;
  // otherwise memory is ready except for rd_waits low cycles in the load read.
  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input int z_f,
                           input int rd_waits);
    int plan[$];
    int cycles, waits, rw_cnt, cpi, rw_exp, mrf, w;
    bit adv, rw;
    opcode = opc; funct3 = f3;
    cycles = 0; waits = 0; rw_cnt = 0;
    case (opc)
      OPCODE__LOAD:   plan = '{K_FETCH, K_DECODE, K_MEMADR, K_MEMRD, K_MEMWB};
      OPCODE__STORE:  plan = '{K_FETCH, K_DECODE, K_MEMADR, K_MEMWR};
      OPCODE__OP:     plan = '{K_FETCH, K_DECODE, K_EXR, K_ALUWB};
      OPCODE__OP_IMM: plan = '{K_FETCH, K_DECODE, K_EXI, K_ALUWB};
      OPCODE__LUI:    plan = '{K_FETCH, K_DECODE, K_LUI, K_ALUWB};
      OPCODE__AUIPC:  plan = '{K_FETCH, K_DECODE, K_ALUWB};
      OPCODE__JAL:    plan = '{K_FETCH, K_DECODE, K_JAL, K_ALUWB};
      OPCODE__JALR:   plan = '{K_FETCH, K_DECODE, K_JALR, K_JLINK};
      OPCODE__BRANCH: plan = '{K_FETCH, K_DECODE, K_BR};
      default:        plan = '{K_FETCH, K_ILL};
    endcase
    // Zero-wait CPI and register writes per instruction class.
    case (opc)
      OPCODE__AUIPC, OPCODE__BRANCH:                 cpi = 3;
      OPCODE__LOAD:                                  cpi = 5;
      OPCODE__OP, OPCODE__OP_IMM, OPCODE__LUI,
      OPCODE__JAL, OPCODE__JALR, OPCODE__STORE:      cpi = 4;
      default:                                       cpi = 2;
    endcase
    case (opc)
      OPCODE__STORE, OPCODE__BRANCH: rw_exp = 0;
      OPCODE__LOAD, OPCODE__OP, OPCODE__OP_IMM, OPCODE__LUI,
      OPCODE__AUIPC, OPCODE__JAL, OPCODE__JALR: rw_exp = 1;
      default: rw_exp = 0;
    endcase
    for (int i = 0; i < plan.size(); i++) begin
      w = 0;
      do begin
        if (rd_waits < 0)          mrf = (w >= 8) ? 1 : 2;
        else if (plan[i] == K_MEMRD) mrf = (w < rd_waits) ? 0 : 1;
        else                       mrf = 1;
        step(plan[i], mrf, z_f, 1'b0, adv, rw);
        cycles++;
        rw_cnt += int'(rw);
        if (!adv) begin waits++; w++; end
      end while (!adv);
    end
    n_checks++;
    assert (cycles === cpi + waits) else begin
      n_fail++;
      $error("FAIL cycles opcode=%b: observed %0d expected %0d", opc, cycles, cpi + waits);
    end
    n_checks++;
    assert (rw_cnt === rw_exp) else begin
      n_fail++;
      $error("FAIL reg_write_count opcode=%b: observed %0d expected %0d", opc, rw_cnt, rw_exp);
    end
  endtask

  logic [6:0] legal_ops [0:8] = '{OPCODE__LOAD, OPCODE__STORE, OPCODE__OP, OPCODE__OP_IMM,
                                  OPCODE__BRANCH, OPCODE__JAL, OPCODE__JALR, OPCODE__LUI,
                                  OPCODE__AUIPC};

  initial begin
    bit adv, rw;
    logic [6:0] opc;
    reset = 1'b1; opcode = 7'd0; funct3 = 3'd0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset held two cycles with memory ready: no strobes, default selects.
    step(K_FETCH, 1, 0, 1'b1, adv, rw);
    step(K_FETCH, 1, 0, 1'b1, adv, rw);

    // R-type first: checks the fetch right after reset, then the R sequence.
    run_instr(OPCODE__OP, 3'b000, 2, 0);
    // Load with three wait cycles in the read phase.
    run_instr(OPCODE__LOAD, 3'b010, 2, 3);
    // Branch resolution corners.
    run_instr(OPCODE__BRANCH, 3'b000, 1, 0);
    run_instr(OPCODE__BRANCH, 3'b001, 1, 0);
    run_instr(OPCODE__BRANCH, 3'b100, 0, 0);
    run_instr(OPCODE__BRANCH, 3'b000, 0, 0);
    // Illegal opcode, then one of each remaining class.
    run_instr(7'b0000000, 3'b000, 2, 0);
    run_instr(OPCODE__STORE, 3'b010, 2, 0);
    run_instr(OPCODE__OP_IMM, 3'b000, 2, 0);
    run_instr(OPCODE__LUI, 3'b000, 2, 0);
    run_instr(OPCODE__AUIPC, 3'b000, 2, 0);
    run_instr(OPCODE__JAL, 3'b000, 2, 0);
    run_instr(OPCODE__JALR, 3'b000, 2, 0);

    // Store stalled on memory, then reset mid-wait: write must drop at once
    // and the next cycle must be a fresh fetch.
    opcode = OPCODE__STORE; funct3 = 3'b010;
    step(K_FETCH, 1, 2, 1'b0, adv, rw);
    step(K_DECODE, 1, 2, 1'b0, adv, rw);
    step(K_MEMADR, 1, 2, 1'b0, adv, rw);
    step(K_MEMWR, 0, 2, 1'b0, adv, rw);
    step(K_MEMWR, 0, 2, 1'b1, adv, rw);
    step(K_FETCH, 1, 2, 1'b0, adv, rw);
    step(K_DECODE, 1, 2, 1'b0, adv, rw);
    step(K_MEMADR, 1, 2, 1'b0, adv, rw);
    step(K_MEMWR, 1, 2, 1'b0, adv, rw);

    // Random instruction stream with random memory waits and zero flags.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 0) opc = 7'($urandom_range(0, 127));
      else                           opc = legal_ops[$urandom_range(0, 8)];
      run_instr(opc, 3'($urandom_range(0, 7)), 2, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
